logic_unit_arbiter: RTL and testbench

- Shares one W-bit bitwise logic unit between N requesters.
- Each request supplies a 2-bit op and two operands. The op encoding is: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- The block picks one requester with round-robin arbitration, latches that request's operands, evaluates the op, and holds a tagged result until the consumer takes it.
- It sits between the requester ports and the result bus. It is the only path through which the logic unit is used.

---
 rtl/logic_unit_arbiter.sv | 130 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit (AND/OR/XOR/XNOR) between N requesters, with a tagged, held result.
// Define LOGIC_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module logic_unit_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned IDW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [2*N-1:0]   req_op,
    input  logic [W*N-1:0]   req_a,
    input  logic [W*N-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_y,
    output logic [IDW-1:0]   rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t         state;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] lat_id;
    logic [1:0]     lat_op;
    logic [W-1:0]   lat_a;
    logic [W-1:0]   lat_b;
    logic [1:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [N-1:0]   grant;
    logic           accept;
    int unsigned    d;
    int unsigned    best_d;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] ptr;
`endif

    // Winner = valid requester with the smallest distance from the search start.
    always_comb begin
        best_d = N;
        d      = 0;
        win_id = '0;
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
            d = i;
`else
            d = (i + N - 32'(ptr)) % N;
`endif
            if (req_valid[i] && (d < best_d)) begin
                best_d = d;
                win_id = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (win_id == IDW'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[W*i +: W];
                sel_b  = req_b[W*i +: W];
            end
        end
    end

    assign grant     = N'(1) << win_id;
    assign req_ready = (rst_n && (state == ST_IDLE) && (|req_valid)) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Control FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_id    <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_id <= win_id;
                        lat_op <= sel_op;
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
                        ptr    <= (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
`endif
                        busy   <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (lat_op)
                        2'b00:   rsp_y <= lat_a & lat_b;
                        2'b01:   rsp_y <= lat_a | lat_b;
                        2'b10:   rsp_y <= lat_a ^ lat_b;
                        default: rsp_y <= ~(lat_a ^ lat_b);
                    endcase
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based arbitration and operation model.
module tb_logic_unit_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [2*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_y;
    logic [IDW-1:0] rsp_id;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;
    int m_ptr    = 0;
    int got;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Priority list starts at the model pointer and wraps; first valid entry wins.
    function automatic int model_winner(input logic [N-1:0] v);
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [W-1:0] model_op(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] y;
        y = '0;
        for (int i = 0; i < W; i++) begin
            case (op)
                2'b00:   y[i] = a[i] & b[i];
                2'b01:   y[i] = a[i] | b[i];
                2'b10:   y[i] = (a[i] != b[i]);
                default: y[i] = (a[i] == b[i]);
            endcase
        end
        return y;
    endfunction

    task automatic set_all(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = op;
            req_a[W*i +: W]  = a;
            req_b[W*i +: W]  = b;
        end
    endtask

    // One transaction from IDLE. mode: 0 keep inputs, 1 zero operand a after accept, 2 randomize after accept.
    task automatic run_txn(input int stall, input int mode, output int w);
        logic [W-1:0] e_y;
        #1;
        w = model_winner(req_valid);
        chk("grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w < 0) begin
            tick();
            return;
        end
        e_y = model_op(req_op[2*w +: 2], req_a[W*w +: W], req_b[W*w +: W]);
        tick();
`ifndef LOGIC_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % N;
`endif
        if (mode == 1) req_a = '0;
        if (mode == 2) begin
            req_a = $urandom;
            req_b = $urandom;
            req_op = 8'($urandom);
            req_valid = 4'($urandom);
        end
        rsp_ready = 1'($urandom);
        #1;
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_y", 32'(rsp_y), 32'(e_y));
        chk("rsp_id", 32'(rsp_id), 32'(w));
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            #1;
            chk("stall_ready", 32'(req_ready), 32'd0);
            tick();
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_y", 32'(rsp_y), 32'(e_y));
            chk("stall_id", 32'(rsp_id), 32'(w));
            chk("stall_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_ready", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_y"}, 32'(rsp_y), 32'd0);
        chk({tag, "_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset with requests pending: grant must stay forced low.
        req_valid = 4'b1111;
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        tick();
        tick();
        chk_all_zero("reset_hold");
        rst_n = 1'b1;
        m_ptr = 0;

        // Round-robin fairness: all requesters valid, five grants.
        set_all(2'b10, 8'h3C, 8'h0F);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) run_txn(0, 0, got);

        // Op sweep on requester 2 alone.
        req_valid = 4'b0100;
        for (int op = 0; op < 4; op++) begin
            set_all(2'(op), 8'hC5, 8'h3A);
            run_txn(0, 0, got);
        end

        // Backpressure: hold rsp_ready low for 10 cycles with everyone requesting.
        set_all(2'b01, 8'hF0, 8'h0F);
        req_valid = 4'b1111;
        run_txn(10, 0, got);
        run_txn(0, 0, got);

        // Operand isolation: a is cleared right after accept.
        set_all(2'b10, 8'hAA, 8'h55);
        run_txn(0, 1, got);

        // Reset in the middle of EXEC.
        set_all(2'b00, 8'hFF, 8'h0F);
        req_valid = 4'b1111;
        #1;
        chk("pre_reset_grant", 32'(req_ready), 32'd1 << model_winner(req_valid));
        tick();
        rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        req_valid = 4'b1001;
        run_txn(0, 0, got);
        req_valid = 4'b1000;
        run_txn(1, 0, got);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            req_valid = 4'($urandom);
            req_op = 8'($urandom);
            req_a = $urandom;
            req_b = $urandom;
            run_txn(int'($urandom_range(0, 3)), 2, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
